pdf_key_search_ctrl: RTL and testbench

Upstream sequencer for the PDF password checker. It enumerates candidate 128-bit keys starting at a base value and requests a decryption of the first ciphertext block for each candidate from the cipher engine. It presents each decrypted 64-bit block with its key to the header checker for one cycle, then stops on a hit or when the candidate range is used up. Results are held for the CPU-side register interface.

---
 rtl/pdf_key_search_ctrl_if.sv | 38 +++
 rtl/pdf_key_search_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pdf_key_search_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdf_key_search_ctrl_if.sv
// Handshake and status bundle of the PDF key search sequencer: launch control,
// cipher engine request/ack, checker strobe and the CPU-visible result flags.
interface pdf_key_search_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [127:0]     base_key;
  logic [CNT_W-1:0] key_count;
  logic             cipher_req;
  logic [127:0]     cipher_key;
  logic             cipher_ack;
  logic [63:0]      cipher_data;
  logic             chk_valid;
  logic [127:0]     chk_key;
  logic [63:0]      chk_data;
  logic             chk_hit;
  logic             busy;
  logic             done;
  logic             found;
  logic             aborted;
  logic [127:0]     found_key;
  logic [CNT_W-1:0] tried;

  // Sequencer side
  modport master (
    input  start, abort, base_key, key_count, cipher_ack, cipher_data, chk_hit,
    output cipher_req, cipher_key, chk_valid, chk_key, chk_data,
           busy, done, found, aborted, found_key, tried
  );

  // Environment side: CPU registers, cipher engine and header checker
  modport slave (
    output start, abort, base_key, key_count, cipher_ack, cipher_data, chk_hit,
    input  cipher_req, cipher_key, chk_valid, chk_key, chk_data,
           busy, done, found, aborted, found_key, tried
  );
endinterface

// File: rtl/pdf_key_search_ctrl.sv
// Candidate key enumerator for the PDF password checker: requests one cipher
// block per candidate, strobes it to the header checker, stops on hit/exhaust/abort.
module pdf_key_search_ctrl #(
  parameter int           CNT_W    = 32,
  parameter logic [127:0] KEY_STEP = 128'd1
) (
  input logic                  clk,
  input logic                  rst,
  pdf_key_search_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [127:0]     cur_key, cur_key_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] kc, kc_nxt;
  logic [CNT_W-1:0] tried, tried_nxt;
  logic             done, done_nxt;
  logic             found, found_nxt;
  logic             aborted, aborted_nxt;
  logic [127:0]     found_key, found_key_nxt;
  logic [127:0]     chk_key, chk_key_nxt;
  logic [63:0]      chk_data, chk_data_nxt;
  logic             cipher_req, chk_valid, busy;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update decode
  always_comb begin
    state_nxt     = state;
    cur_key_nxt   = cur_key;
    idx_nxt       = idx;
    kc_nxt        = kc;
    tried_nxt     = tried;
    done_nxt      = done;
    found_nxt     = found;
    aborted_nxt   = aborted;
    found_key_nxt = found_key;
    chk_key_nxt   = chk_key;
    chk_data_nxt  = chk_data;

    case (state)
      IDLE, DONE: begin
        // start outranks abort here; abort alone is ignored while idle
        if (bus.start) begin
          cur_key_nxt = bus.base_key;
          kc_nxt      = bus.key_count;
          idx_nxt     = {CNT_W{1'b0}};
          tried_nxt   = {CNT_W{1'b0}};
          found_nxt   = 1'b0;
          aborted_nxt = 1'b0;
          if (bus.key_count == {CNT_W{1'b0}}) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = REQ;
            done_nxt  = 1'b0;
          end
        end else begin
          state_nxt = state;
        end
      end

      REQ: begin
        // abort discards a coinciding ack
        if (bus.abort) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (bus.cipher_ack) begin
          state_nxt    = CHECK;
          chk_key_nxt  = cur_key;
          chk_data_nxt = bus.cipher_data;
        end else begin
          state_nxt = REQ;
        end
      end

      CHECK: begin
        tried_nxt = tried + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bus.chk_hit) begin
          state_nxt     = DONE;
          done_nxt      = 1'b1;
          found_nxt     = 1'b1;
          found_key_nxt = cur_key;
        end else if (bus.abort) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (idx == kc - {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt   = REQ;
          cur_key_nxt = cur_key + KEY_STEP;
          idx_nxt     = idx + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_key   <= 128'd0;
      idx       <= {CNT_W{1'b0}};
      kc        <= {CNT_W{1'b0}};
      tried     <= {CNT_W{1'b0}};
      done      <= 1'b0;
      found     <= 1'b0;
      aborted   <= 1'b0;
      found_key <= 128'd0;
      chk_key   <= 128'd0;
      chk_data  <= 64'd0;
    end else begin
      cur_key   <= cur_key_nxt;
      idx       <= idx_nxt;
      kc        <= kc_nxt;
      tried     <= tried_nxt;
      done      <= done_nxt;
      found     <= found_nxt;
      aborted   <= aborted_nxt;
      found_key <= found_key_nxt;
      chk_key   <= chk_key_nxt;
      chk_data  <= chk_data_nxt;
    end
  end

  // Strobes registered from the next state so they track the state register exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_req <= 1'b0;
      chk_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cipher_req <= (state_nxt == REQ);
      chk_valid  <= (state_nxt == CHECK);
      busy       <= (state_nxt == REQ) || (state_nxt == CHECK);
    end
  end

  assign bus.cipher_req = cipher_req;
  assign bus.cipher_key = cur_key;
  assign bus.chk_valid  = chk_valid;
  assign bus.chk_key    = chk_key;
  assign bus.chk_data   = chk_data;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.found      = found;
  assign bus.aborted    = aborted;
  assign bus.found_key  = found_key;
  assign bus.tried      = tried;

endmodule

// File: tb/tb_pdf_key_search_ctrl.sv
// Scoreboard bench for pdf_key_search_ctrl: directed searches push expected checker
// strobes and results; a negedge monitor pops and compares them as the DUT presents them.
module tb_pdf_key_search_ctrl;
  localparam int          CNT_W = 32;
  localparam logic [63:0] XMASK = 64'hDEAD_BEEF_0123_4567;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  data;
  } chk_t;

  typedef struct {
    logic             found;
    logic             aborted;
    logic [127:0]     key;
    logic [CNT_W-1:0] tried;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdf_key_search_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pdf_key_search_ctrl #(.CNT_W(CNT_W), .KEY_STEP(128'd1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;
  chk_t chk_q[$];
  res_t res_q[$];
  int ack_delay = 0;
  int hit_at    = 0;
  int chk_cnt   = 0;
  int reqs      = 0;
  int wcnt      = 0;
  logic         done_prev = 1'b0;
  logic         req_prev  = 1'b0;
  logic         exp_chk   = 1'b0;
  logic [127:0] key_prev  = 128'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_chk(input logic [127:0] key);
    chk_t e;
    e.key  = key;
    e.data = key[63:0] ^ XMASK;
    chk_q.push_back(e);
  endtask

  task automatic push_res(input logic f, input logic a, input logic [127:0] k, input int t);
    res_t r;
    r.found   = f;
    r.aborted = a;
    r.key     = k;
    r.tried   = CNT_W'(t);
    res_q.push_back(r);
  endtask

  task automatic launch(input logic [127:0] b, input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_key  = b;
    bus.key_count = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, expected 1", name, bus.done, n);
    end
    @(negedge clk); #1;
    check({name, "_chk_q_empty"}, chk_q.size(), 0);
    check({name, "_res_q_empty"}, res_q.size(), 0);
  endtask

  // Checker model: hit on the hit_at-th strobe of the current search
  assign bus.chk_hit = bus.chk_valid && (hit_at != 0) && (chk_cnt == hit_at - 1);

  always @(posedge clk) begin
    if (bus.start && !bus.busy) chk_cnt <= 0;
    else if (bus.chk_valid)     chk_cnt <= chk_cnt + 1;
    exp_chk <= bus.cipher_req && bus.cipher_ack && !bus.abort;
  end

  // Cipher engine model: ack after ack_delay wait cycles, one-cycle ack pulse
  always @(negedge clk) begin
    if (rst) begin
      bus.cipher_ack = 1'b0;
      wcnt = 0;
    end else if (bus.cipher_ack) begin
      bus.cipher_ack = 1'b0;
    end else if (bus.cipher_req) begin
      if (wcnt >= ack_delay) begin
        bus.cipher_ack  = 1'b1;
        bus.cipher_data = bus.cipher_key[63:0] ^ XMASK;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: strobe latency, request stability, scoreboard pops
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.chk_valid || exp_chk) check("chk_latency", bus.chk_valid, exp_chk);
      if (bus.chk_valid) begin
        if (chk_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL chk_unexpected: strobe with key %0h, expected none", bus.chk_key);
        end else begin
          chk_t e;
          e = chk_q.pop_front();
          check("chk_key", bus.chk_key, e.key);
          check("chk_data", bus.chk_data, e.data);
        end
      end
      if (bus.cipher_req && req_prev) check("req_key_stable", bus.cipher_key, key_prev);
      if (bus.start && !bus.busy)            reqs = 0;
      else if (bus.cipher_req && !req_prev) reqs++;
      if (bus.done && !done_prev) begin
        if (res_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL res_unexpected: done with tried=%0d, expected none", bus.tried);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("res_found", bus.found, r.found);
          check("res_aborted", bus.aborted, r.aborted);
          check("res_tried", bus.tried, r.tried);
          check("res_busy", bus.busy, 1'b0);
          if (r.found) check("res_found_key", bus.found_key, r.key);
        end
      end
      done_prev = bus.done;
      req_prev  = bus.cipher_req;
      key_prev  = bus.cipher_key;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_key  = 128'd0;
    bus.key_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {bus.busy, bus.done, bus.found, bus.aborted, bus.cipher_req, bus.chk_valid}, 6'd0);
    check("rst_tried", bus.tried, 0);
    check("rst_found_key", bus.found_key, 128'd0);
    check("rst_cipher_key", bus.cipher_key, 128'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_flags", {bus.busy, bus.done, bus.cipher_req, bus.chk_valid}, 4'd0);

    // Empty range
    push_res(1'b0, 1'b0, 128'd0, 0);
    launch(128'h1234, '0);
    check("kc0_done_next_cycle", bus.done, 1'b1);
    wait_done("kc0");
    check("kc0_reqs", reqs, 0);

    // Hit on third candidate
    hit_at = 3;
    push_chk(128'hFF); push_chk(128'h100); push_chk(128'h101);
    push_res(1'b1, 1'b0, 128'h101, 3);
    launch(128'hFF, 32'd4);
    wait_done("hit3");
    check("hit3_reqs", reqs, 3);

    // Range exhausted, no hit
    hit_at = 0;
    push_chk(128'hFF); push_chk(128'h100); push_chk(128'h101); push_chk(128'h102);
    push_res(1'b0, 1'b0, 128'd0, 4);
    launch(128'hFF, 32'd4);
    wait_done("nohit");
    check("nohit_reqs", reqs, 4);

    // 128-bit wrap and a carry across the 64-bit boundary
    push_chk(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF); push_chk(128'd0);
    push_res(1'b0, 1'b0, 128'd0, 2);
    launch(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'd2);
    wait_done("wrap");
    push_chk(128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF);
    push_chk(128'h0000_0000_0000_0002_0000_0000_0000_0000);
    push_res(1'b0, 1'b0, 128'd0, 2);
    launch(128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 32'd2);
    wait_done("carry64");

    // Slow ack, start while busy ignored
    ack_delay = 5;
    hit_at    = 1;
    push_chk(128'hCAFE);
    push_res(1'b1, 1'b0, 128'hCAFE, 1);
    launch(128'hCAFE, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("busy_during_req", bus.busy, 1'b1);
    bus.start = 1'b1; bus.base_key = 128'h999; bus.key_count = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("slow_ack");

    // Abort coinciding with ack
    ack_delay = 2;
    hit_at    = 0;
    push_res(1'b0, 1'b1, 128'd0, 0);
    launch(128'h500, 32'd3);
    begin
      int n = 0;
      while (!bus.cipher_ack && n < 100) begin
        @(bus.cipher_ack or posedge clk);
        n++;
      end
      if (!bus.cipher_ack) begin
        checks++;
        fails++;
        $display("FAIL abort_ack_timeout: cipher_ack=%0b, expected 1", bus.cipher_ack);
      end
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    wait_done("abort_ack");

    // Relaunch from DONE clears the flags
    ack_delay = 0;
    push_chk(128'h777);
    push_res(1'b0, 1'b0, 128'd0, 1);
    launch(128'h777, 32'd1);
    check("relaunch_flags", {bus.done, bus.found, bus.aborted, bus.busy}, 4'b0001);
    wait_done("relaunch");

    // Abort together with a hit: the hit wins
    hit_at = 1;
    push_chk(128'hABC);
    push_res(1'b1, 1'b0, 128'hABC, 1);
    launch(128'hABC, 32'd2);
    begin
      int n = 0;
      while (!bus.chk_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    wait_done("abort_hit");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
